// File: rtl/dnn_result_argmax.sv
// Classification back-end: captures a vector of signed class scores, scans it
// sequentially for the argmax and serves a registered indexed readout of the bank.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | result (if valid) held; waiting for a start pulse
// ST_SCAN | walking the captured bank, tracking best value and index
module dnn_result_argmax #(
  parameter int DATA_WIDTH  = 6,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_clear,
  input  logic                              i_start,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] i_in_scores,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_valid,
  output logic [IDX_WIDTH-1:0]              o_class_out,
  output logic signed [DATA_WIDTH-1:0]      o_max_out,
  input  logic [IDX_WIDTH-1:0]              i_rd_idx,
  output logic signed [DATA_WIDTH-1:0]      o_rd_data
);

  localparam int CNT_W = IDX_WIDTH + 1;
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(NUM_CLASSES);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t                       r_state;
  logic signed [DATA_WIDTH-1:0] r_bank [NUM_CLASSES];
  logic [CNT_W-1:0]             r_cnt;
  logic signed [DATA_WIDTH-1:0] r_best;
  logic [IDX_WIDTH-1:0]         r_best_idx;
  logic [IDX_WIDTH-1:0]         r_class;
  logic signed [DATA_WIDTH-1:0] r_max;
  logic signed [DATA_WIDTH-1:0] r_rd_data;
  logic                         r_busy;
  logic                         r_done;
  logic                         r_valid;

  logic signed [DATA_WIDTH-1:0] w_cur;
  logic signed [DATA_WIDTH-1:0] w_rd_sel;

  // Explicit muxes keep out-of-range indices on bank[0] instead of reading past the array.
  always_comb begin
    w_cur    = r_bank[0];
    w_rd_sel = r_bank[0];
    for (int k = 1; k < NUM_CLASSES; k++) begin
      if (r_cnt == CNT_W'(k))        w_cur    = r_bank[k];
      if (i_rd_idx == IDX_WIDTH'(k)) w_rd_sel = r_bank[k];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      for (int k = 0; k < NUM_CLASSES; k++) r_bank[k] <= '0;
      r_cnt      <= '0;
      r_best     <= '0;
      r_best_idx <= '0;
      r_class    <= '0;
      r_max      <= '0;
      r_rd_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
    end else if (i_clear) begin
      r_state    <= ST_IDLE;
      for (int k = 0; k < NUM_CLASSES; k++) r_bank[k] <= '0;
      r_cnt      <= '0;
      r_best     <= '0;
      r_best_idx <= '0;
      r_class    <= '0;
      r_max      <= '0;
      r_rd_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_rd_data <= w_rd_sel;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            for (int k = 0; k < NUM_CLASSES; k++)
              r_bank[k] <= i_in_scores[k*DATA_WIDTH +: DATA_WIDTH];
            r_best     <= i_in_scores[DATA_WIDTH-1:0];
            r_best_idx <= '0;
            r_cnt      <= CNT_W'(1);
            r_valid    <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (r_cnt == LP_LAST) begin
            r_max   <= r_best;
            r_class <= r_best_idx;
            r_done  <= 1'b1;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            // Strictly greater: on ties the earliest class keeps the win.
            if (w_cur > r_best) begin
              r_best     <= w_cur;
              r_best_idx <= r_cnt[IDX_WIDTH-1:0];
            end
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_valid     = r_valid;
  assign o_class_out = r_class;
  assign o_max_out   = r_max;
  assign o_rd_data   = r_rd_data;

endmodule
